uart_cmd_resp: RTL and testbench
================================

Name: uart_cmd_resp

Overview:
- DUT-side endpoint of the remote-command UART link. It is the responder to the host's command initiator.
- Receives 8N1 serial bytes on RX and assembles byte pairs into a 16-bit command (high byte first), presented with a cmd_rdy flag.
- Serializes single 8-bit responses (e.g. 8'hA5 / 8'h5A) back out on TX.
- Sits between the chip RX/TX pins and the command processor / tour FSM.

Parameters:
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); legal range 16..4095.
- TO_BITS, 22: width of inter-byte timeout counter (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- RX  in  1  serial input, idles high, asynchronous to clk
- TX  out  1  serial output, idles high
- cmd  out  16  assembled command {first byte, second byte}
- cmd_rdy  out  1  command valid flag
- clr_cmd_rdy  in  1  consumer clears cmd_rdy
- resp  in  8  response byte to transmit
- send_resp  in  1  one-cycle strobe that loads resp and starts transmission
- resp_sent  out  1  level, high when the transmitter is idle / last response done
- frm_err  out  1  one-cycle pulse on a receive stop-bit error

Behaviour:
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=1, frm_err=0. All FSMs go to IDLE. RX synchronizers preset to 1.
- RX path:
  - RX passes through a 2-flop synchronizer; a third flop is used for edge detect.
  - States IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge loads the baud counter with BAUD_DIV/2.
  - START: at mid-bit, if RX is still 0 go to DATA, else treat as a glitch and return to IDLE.
  - DATA: shift 8 bits LSB-first, each sampled at mid-bit (counter reloaded with BAUD_DIV).
  - STOP: sample at mid-bit. If 1, the byte is valid. If 0, pulse frm_err, discard the byte and return to IDLE.
- Byte assembly (flag hi_pending):
  - First valid byte goes into cmd[15:8]; set hi_pending.
  - Second valid byte goes into cmd[7:0]; clear hi_pending; set cmd_rdy in the same cycle the low byte is written.
  - Byte-valid to cmd_rdy latency is 1 clk.
  - A framing error clears hi_pending, so the next byte is treated as a high byte.
- cmd_rdy clear rules:
  - Cleared by clr_cmd_rdy.
  - Cleared when a new high byte is accepted.
  - If clr_cmd_rdy and set-cmd_rdy occur in the same cycle, set wins.
  - cmd holds its value until overwritten.
- TX path:
  - States IDLE -> XMIT.
  - send_resp in IDLE loads the shift register with {1'b1, resp, 1'b0}, drops resp_sent, and enters XMIT.
  - XMIT shifts LSB-first, one bit per BAUD_DIV clks, for 10 bits.
  - resp_sent rises the cycle after the stop bit completes.
  - send_resp while XMIT is ignored; there is no queue.
  - send_resp in the same cycle as completion is accepted, and resp_sent stays low.
- Independence: RX and TX are full duplex and share no state.
- Reset mid-frame: both paths abort immediately, TX returns high and partial bytes are lost.

Optional Feature:
- Macro: UART_CMD_BYTE_TIMEOUT_EN.
- Defined:
  - While hi_pending=1, a TO_BITS-wide counter increments every clk.
  - The counter is cleared when a byte is received or hi_pending clears.
  - On saturation (all ones), hi_pending clears, so a lone high byte is dropped and the next byte is treated as a high byte. cmd_rdy is not set.
- Undefined:
  - No counter.
  - hi_pending persists indefinitely until a second byte or a framing error.

Test Plan:
- Reset: rst pulse mid-frame on both RX and TX -> TX=1, cmd_rdy=0, cmd=0, resp_sent=1 within 0 clks of rst assertion.
- Command receive: host sends 16'h2A53 (0x2A then 0x53) at BAUD_DIV=2604 -> cmd=16'h2A53 and cmd_rdy=1 one clk after the second stop-bit sample; clr_cmd_rdy pulse -> cmd_rdy=0.
- Response transmit: send_resp with resp=8'hA5 -> TX waveform start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 2604 clks; resp_sent high after 26040 clks; host decodes 8'hA5. Repeat with 8'h5A.
- Framing error: 0x12 with stop bit forced 0, then 0x34, 0x56 -> one frm_err pulse; cmd=16'h3456, cmd_rdy=1.
- Full duplex: send_resp 8'h5A while host sends 16'h7F01 simultaneously -> both complete correctly; new command clears a stale cmd_rdy on the high byte.
- Timeout (macro defined, TO_BITS=8): lone byte 0x11, idle 300 clks, then 0x22, 0x33 -> cmd=16'h2233. Macro undefined: same stimulus -> cmd=16'h1122.

Source files
------------

// File: rtl/uart_cmd_resp.sv
// 8N1 UART responder: assembles byte pairs into 16-bit commands and serializes 8-bit responses.
// Optional UART_CMD_BYTE_TIMEOUT_EN drops a lone high byte after 2**TO_BITS-1 idle clocks.
module uart_cmd_resp #(
    parameter int BAUD_DIV = 2604,
    parameter int TO_BITS  = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx,
    output logic        o_tx,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    input  logic [7:0]  i_resp,
    input  logic        i_send_resp,
    output logic        o_resp_sent,
    output logic        o_frm_err
);

    if (BAUD_DIV < 16 || BAUD_DIV > 4095 || TO_BITS < 2) begin : g_bad_param
        $error("uart_cmd_resp: BAUD_DIV must be 16..4095 and TO_BITS >= 2");
    end

    localparam logic [11:0] L_FULL = 12'(BAUD_DIV - 1);
    localparam logic [11:0] L_HALF = 12'(BAUD_DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    rx_state_t   r_rx_state;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic [11:0] r_rx_cnt;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_sr;
    logic        r_rx_done;
    logic        r_frm_err;
    logic        r_hi_pending;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    tx_state_t   r_tx_state;
    logic [9:0]  r_tx_sr;
    logic [11:0] r_tx_cnt;
    logic [3:0]  r_tx_bits;
    logic        r_resp_sent;
    logic        w_rx_fall;

    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    // NOTE: synchronizer flops reset to 1 (line idle) so leaving reset never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_sr    <= '0;
            r_rx_done  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_s3   <= r_rx_s2;
            r_rx_done <= 1'b0;
            r_frm_err <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_cnt   <= L_HALF;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != 12'd0) begin
                        r_rx_cnt <= r_rx_cnt - 12'd1;
                    end else if (!r_rx_s2) begin
                        r_rx_cnt   <= L_FULL;
                        r_rx_bits  <= '0;
                        r_rx_state <= RX_DATA;
                    end else begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != 12'd0) begin
                        r_rx_cnt <= r_rx_cnt - 12'd1;
                    end else begin
                        r_rx_sr   <= {r_rx_s2, r_rx_sr[7:1]};
                        r_rx_cnt  <= L_FULL;
                        r_rx_bits <= r_rx_bits + 3'd1;
                        if (r_rx_bits == 3'd7) r_rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt != 12'd0) begin
                        r_rx_cnt <= r_rx_cnt - 12'd1;
                    end else begin
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s2) r_rx_done <= 1'b1;
                        else         r_frm_err <= 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_CMD_BYTE_TIMEOUT_EN
    logic [TO_BITS-1:0] r_to_cnt;
`endif

    // A completed low byte sets cmd_rdy and takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd        <= '0;
            r_cmd_rdy    <= 1'b0;
            r_hi_pending <= 1'b0;
`ifdef UART_CMD_BYTE_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            if (i_clr_cmd_rdy) r_cmd_rdy <= 1'b0;
            if (r_rx_done) begin
                if (!r_hi_pending) begin
                    r_cmd[15:8]  <= r_rx_sr;
                    r_hi_pending <= 1'b1;
                    r_cmd_rdy    <= 1'b0;
                end else begin
                    r_cmd[7:0]   <= r_rx_sr;
                    r_hi_pending <= 1'b0;
                    r_cmd_rdy    <= 1'b1;
                end
            end else if (r_frm_err) begin
                r_hi_pending <= 1'b0;
            end
`ifdef UART_CMD_BYTE_TIMEOUT_EN
            if (r_rx_done || !r_hi_pending) begin
                r_to_cnt <= '0;
            end else if (&r_to_cnt) begin
                r_to_cnt     <= '0;
                r_hi_pending <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_sr     <= '1;
            r_tx_cnt    <= '0;
            r_tx_bits   <= '0;
            r_resp_sent <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (i_send_resp) begin
                        r_tx_sr     <= {1'b1, i_resp, 1'b0};
                        r_tx_cnt    <= L_FULL;
                        r_tx_bits   <= '0;
                        r_resp_sent <= 1'b0;
                        r_tx_state  <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (r_tx_cnt != 12'd0) begin
                        r_tx_cnt <= r_tx_cnt - 12'd1;
                    end else if (r_tx_bits == 4'd9) begin
                        // Back-to-back request at completion restarts without raising resp_sent.
                        if (i_send_resp) begin
                            r_tx_sr   <= {1'b1, i_resp, 1'b0};
                            r_tx_cnt  <= L_FULL;
                            r_tx_bits <= '0;
                        end else begin
                            r_tx_sr     <= '1;
                            r_resp_sent <= 1'b1;
                            r_tx_state  <= TX_IDLE;
                        end
                    end else begin
                        r_tx_sr   <= {1'b1, r_tx_sr[9:1]};
                        r_tx_cnt  <= L_FULL;
                        r_tx_bits <= r_tx_bits + 4'd1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign o_tx        = r_tx_sr[0];
    assign o_cmd       = r_cmd;
    assign o_cmd_rdy   = r_cmd_rdy;
    assign o_resp_sent = r_resp_sent;
    assign o_frm_err   = r_frm_err;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Self-checking bench for uart_cmd_resp: directed and random commands/responses against a byte-level model.
module tb_uart_cmd_resp;
    localparam int B   = 16;
    localparam int TOB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send = 1'b0;
    logic        resp_sent;
    logic        frm_err;

    int n_chk = 0;
    int n_fail = 0;
    int frm_cnt = 0;

    logic [15:0] m_cmd = 16'h0000;
    bit          m_rdy = 1'b0;
    bit          m_pend = 1'b0;

    uart_cmd_resp #(.BAUD_DIV(B), .TO_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .i_rx(rx), .o_tx(tx), .o_cmd(cmd), .o_cmd_rdy(cmd_rdy),
        .i_clr_cmd_rdy(clr), .i_resp(resp), .i_send_resp(send),
        .o_resp_sent(resp_sent), .o_frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frm_err === 1'b1) frm_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: bytes pair up high-then-low; framing errors and long gaps forget a pending high byte.
    task automatic m_byte(input logic [7:0] b);
        if (!m_pend) begin
            m_cmd[15:8] = b;
            m_pend = 1'b1;
            m_rdy = 1'b0;
        end else begin
            m_cmd[7:0] = b;
            m_pend = 1'b0;
            m_rdy = 1'b1;
        end
    endtask

    task automatic m_idle(input int cycles);
`ifdef UART_CMD_BYTE_TIMEOUT_EN
        if (m_pend && cycles >= (1 << TOB)) m_pend = 1'b0;
`else
        if (cycles < 0) m_pend = 1'b0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        @(negedge clk) rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = good;
        repeat (B) @(negedge clk);
        rx = 1'b1;
        if (good) m_byte(b);
        else begin
            m_pend = 1'b0;
            repeat (B) @(negedge clk);
        end
        chk($sformatf("cmd_after_%02h", b), 32'(cmd), 32'(m_cmd));
        chk($sformatf("cmd_rdy_after_%02h", b), 32'(cmd_rdy), 32'(m_rdy));
    endtask

    task automatic clr_pulse();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        m_rdy = 1'b0;
        chk("cmd_rdy_after_clr", 32'(cmd_rdy), 32'(m_rdy));
    endtask

    task automatic tx_start(input logic [7:0] r);
        for (int i = 0; i < 12 * B && resp_sent !== 1'b1; i++) @(negedge clk);
        chk("tx_idle_before_send", 32'(resp_sent), 32'd1);
        resp = r;
        send = 1'b1;
        @(negedge clk) send = 1'b0;
        chk("resp_sent_low_on_start", 32'(resp_sent), 32'd0);
    endtask

    // Samples each bit at its centre; a mid-frame send request must be ignored.
    task automatic tx_run(input logic [7:0] exp, input bit chain, input logic [7:0] nxt);
        logic [9:0] f;
        repeat (B / 2) @(negedge clk);
        f[0] = tx;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) begin
                resp = ~exp;
                send = 1'b1;
                @(negedge clk) send = 1'b0;
                repeat (B - 1) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
            f[k] = tx;
        end
        repeat (B / 2 - 1) @(negedge clk);
        chk($sformatf("tx_frame_%02h", exp), 32'(f), 32'({1'b1, exp, 1'b0}));
        chk("resp_sent_low_before_done", 32'(resp_sent), 32'd0);
        if (chain) begin
            resp = nxt;
            send = 1'b1;
        end
        @(negedge clk) send = 1'b0;
        chk("resp_sent_after_frame", 32'(resp_sent), chain ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [7:0] hi, lo, r;
        int fe0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_resp_sent", 32'(resp_sent), 32'd1);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_byte(8'h2A, 1'b1);
        send_byte(8'h53, 1'b1);
        clr_pulse();
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);

        // Reset in the middle of both an RX and a TX frame.
        tx_start(8'h00);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_cmd", 32'(cmd), 32'd0);
        chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("midrst_resp_sent", 32'(resp_sent), 32'd1);
        m_cmd = 16'h0000;
        m_rdy = 1'b0;
        m_pend = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);

        tx_start(8'hA5);
        tx_run(8'hA5, 1'b1, 8'h5A);
        tx_run(8'h5A, 1'b0, 8'h00);

        // Short low glitch must not start a byte.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);

        fe0 = frm_cnt;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        chk("frm_err_pulses", 32'(frm_cnt - fe0), 32'd1);

        fork
            begin
                send_byte(8'h7F, 1'b1);
                send_byte(8'h01, 1'b1);
            end
            begin
                tx_start(8'h5A);
                tx_run(8'h5A, 1'b0, 8'h00);
            end
        join

        send_byte(8'h11, 1'b1);
        repeat (300) @(negedge clk);
        m_idle(300);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        if (m_pend) begin
            send_byte(8'h44, 1'b1);
        end

        for (int n = 0; n < 6; n++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            r  = 8'($urandom);
            fork
                begin
                    send_byte(hi, 1'b1);
                    send_byte(lo, 1'b1);
                end
                begin
                    tx_start(r);
                    tx_run(r, 1'b0, 8'h00);
                end
            join
            if ($urandom_range(0, 1) == 1) clr_pulse();
        end

        chk("frm_err_total", 32'(frm_cnt - fe0), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
